// File: rtl/ch_seq_if.sv
// Channel-side bundle between the job sequencer and the
// channel FIFOs / bus master pair.
interface ch_seq_if;
  logic        m_reset;
  logic        src_start;
  logic        src_stop;
  logic        rd_req;
  logic        src_xfer;
  logic        src_last;
  logic        dst_start;
  logic        dst_end;
  logic        wr_req;
  logic        dst_xfer;
  logic [15:0] ocnt;

  modport master (
    output m_reset,
    output rd_req,
    output src_last,
    output wr_req,
    input  src_start,
    input  src_stop,
    input  src_xfer,
    input  dst_start,
    input  dst_end,
    input  dst_xfer,
    input  ocnt
  );

  modport slave (
    input  m_reset,
    input  rd_req,
    input  src_last,
    input  wr_req,
    output src_start,
    output src_stop,
    output src_xfer,
    output dst_start,
    output dst_end,
    output dst_xfer,
    output ocnt
  );
endinterface

// File: rtl/ch_seq.sv
// Job sequencer for one compression channel: clears the
// channel, paces source/destination requests, reports done.
module ch_seq #(
  parameter int BEAT_BYTES = 8,
  parameter int TMO_W      = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic        abort,
  input  logic [23:0] dc,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] result_cnt,
  ch_seq_if.master    ch
);

  localparam int SH = $clog2(BEAT_BYTES);
  localparam logic [TMO_W-1:0] TMO_LAST =
    {{(TMO_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic [20:0]      src_rem_q;
  logic [20:0]      src_rem_d;
  logic             rd_en_q;
  logic             rd_en_d;
  logic             end_seen_q;
  logic             clr_cnt_q;
  logic             err_q;
  logic [15:0]      result_q;
  logic [TMO_W-1:0] wdog_q;
  logic [TMO_W-1:0] wdog_d;

  logic [24:0] len_sum;
  logic [20:0] beats;
  logic        run;
  logic        rem_zero;
  logic        any_xfer;
  logic        end_now;
  logic        tmo;
  logic        bad_xfer;
  logic        bad_end;

  assign len_sum  = {1'b0, dc} + 25'(BEAT_BYTES - 1);
  assign beats    = 21'(len_sum >> SH);
  assign run      = (state_q == RUN);
  assign rem_zero = (src_rem_q == '0);
  assign any_xfer = ch.src_xfer | ch.dst_xfer;
  assign end_now  = end_seen_q | (ch.dst_end & rem_zero);
  // Counter reaches all-ones on the edge that leaves RUN.
  assign tmo      = !any_xfer & (wdog_q == TMO_LAST);
  assign bad_xfer = ch.src_xfer & (!run | rem_zero);
  assign bad_end  = run & ch.dst_end & !rem_zero;

  always_comb begin
    src_rem_d = src_rem_q;
    if (ch.src_xfer && !rem_zero)
      src_rem_d = src_rem_q - 21'd1;
    wdog_d = any_xfer ? '0 : wdog_q + 1'b1;
    rd_en_d = rd_en_q;
    if (ch.src_stop || rem_zero)
      rd_en_d = 1'b0;
    else if (ch.src_start)
      rd_en_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      src_rem_q  <= '0;
      rd_en_q    <= 1'b0;
      end_seen_q <= 1'b0;
      clr_cnt_q  <= 1'b0;
      err_q      <= 1'b0;
      result_q   <= '0;
      wdog_q     <= '0;
    end else begin
      if (bad_xfer || bad_end)
        err_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            src_rem_q  <= beats;
            err_q      <= 1'b0;
            result_q   <= '0;
            wdog_q     <= '0;
            rd_en_q    <= 1'b0;
            end_seen_q <= 1'b0;
            clr_cnt_q  <= 1'b0;
            if (dc == '0) begin
              err_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= CLR;
            end
          end
        end
        CLR: begin
          wdog_q <= '0;
          if (abort) begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end else if (clr_cnt_q) begin
            state_q <= RUN;
          end else begin
            clr_cnt_q <= 1'b1;
          end
        end
        RUN: begin
          src_rem_q <= src_rem_d;
          wdog_q    <= wdog_d;
          rd_en_q   <= rd_en_d;
          if (ch.dst_end && rem_zero)
            end_seen_q <= 1'b1;
          if (abort) begin
            err_q    <= 1'b1;
            result_q <= '0;
            rd_en_q  <= 1'b0;
            state_q  <= DONE;
          end else if (tmo) begin
            err_q    <= 1'b1;
            result_q <= ch.ocnt;
            rd_en_q  <= 1'b0;
            state_q  <= DONE;
          end else if (end_now) begin
            result_q <= ch.ocnt;
            rd_en_q  <= 1'b0;
            state_q  <= DONE;
          end
        end
        DONE: begin
          end_seen_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = (state_q == CLR) | run;
  assign done       = (state_q == DONE);
  assign err        = err_q;
  assign result_cnt = result_q;

  assign ch.m_reset  = (state_q == CLR) | (run & abort);
  assign ch.rd_req   = run & rd_en_q & !rem_zero & !abort;
  assign ch.wr_req   = run & ch.dst_start & !end_seen_q
                     & !abort;
  assign ch.src_last = run & (src_rem_q == 21'd1);

endmodule

// File: tb/tb_ch_seq.sv
// Directed bench for ch_seq: vector table for a short job
// and dc=0, plus hand sequences for the multi-cycle cases.
module tb_ch_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start, abort;
  logic [23:0] dc;
  logic        busy, done, err;
  logic [15:0] result_cnt;

  logic        start4;
  logic [23:0] dc4;
  logic        busy4, done4, err4;
  logic [15:0] result4;

  ch_seq_if chi();
  ch_seq_if chi4();

  ch_seq #(.BEAT_BYTES(8), .TMO_W(16)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .start      (start),
    .abort      (abort),
    .dc         (dc),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .result_cnt (result_cnt),
    .ch         (chi.master)
  );

  ch_seq #(.BEAT_BYTES(8), .TMO_W(4)) dut4 (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .start      (start4),
    .abort      (1'b0),
    .dc         (dc4),
    .busy       (busy4),
    .done       (done4),
    .err        (err4),
    .result_cnt (result4),
    .ch         (chi4.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] outs();
    return {busy, done, err, chi.m_reset,
            chi.rd_req, chi.wr_req, chi.src_last};
  endfunction

  task automatic idle_in();
    start         = 1'b0;
    abort         = 1'b0;
    dc            = '0;
    chi.src_start = 1'b0;
    chi.src_stop  = 1'b0;
    chi.src_xfer  = 1'b0;
    chi.dst_start = 1'b0;
    chi.dst_end   = 1'b0;
    chi.dst_xfer  = 1'b0;
    chi.ocnt      = '0;
  endtask

  typedef struct {
    logic        st;
    logic        ab;
    logic [23:0] d;
    logic        ss, sp, sx, ds, de, dx;
    logic [15:0] oc;
    logic [6:0]  eo;
    logic [15:0] er;
  } vec_t;

  function automatic vec_t mk(
    input logic st, input logic [23:0] d,
    input logic ss, input logic sx,
    input logic ds, input logic de, input logic dx,
    input logic [15:0] oc,
    input logic [6:0] eo, input logic [15:0] er);
    vec_t v;
    v.st = st; v.ab = 1'b0; v.d = d;
    v.ss = ss; v.sp = 1'b0; v.sx = sx;
    v.ds = ds; v.de = de; v.dx = dx;
    v.oc = oc; v.eo = eo; v.er = er;
    return v;
  endfunction

  // Outputs {busy,done,err,m_reset,rd_req,wr_req,src_last}
  vec_t tbl[14];

  task automatic run_job(input logic [23:0] d,
                         input logic [15:0] oc,
                         output logic e,
                         output logic [15:0] r,
                         output int seen);
    int beats;
    int cnt;
    beats = (int'(d) + 7) / 8;
    cnt   = 0;
    seen  = 0;
    e     = 1'b0;
    r     = '0;
    start = 1'b1;
    dc    = d;
    cyc();
    start         = 1'b0;
    chi.src_start = 1'b1;
    chi.dst_start = 1'b1;
    chi.ocnt      = oc;
    for (int k = 0; k < 200; k++) begin
      chi.src_xfer = 1'b0;
      chi.dst_end  = (cnt == beats);
      #1;
      if (done) begin
        seen = 1;
        e    = err;
        r    = result_cnt;
        break;
      end
      chi.src_xfer = chi.rd_req;
      if (chi.rd_req) cnt++;
      cyc();
    end
    idle_in();
  endtask

  initial begin
    int   cnt, stop_k, gap_bad, last_bad, first;
    logic je;
    logic [15:0] jr;
    int   js;

    tbl[0]  = mk(1, 24'd20, 1, 0, 0, 0, 0, 0,
                 7'b0000000, 0);
    tbl[1]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 7'b1001000, 0);
    tbl[2]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 7'b1001000, 0);
    tbl[3]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 7'b1000000, 0);
    tbl[4]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 7'b1000100, 0);
    tbl[5]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 7'b1000100, 0);
    tbl[6]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 7'b1000101, 0);
    tbl[7]  = mk(0, 0, 1, 0, 1, 0, 1, 5, 7'b1000010, 0);
    tbl[8]  = mk(0, 0, 1, 0, 1, 1, 0, 7, 7'b1000010, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 9, 7'b0100000, 7);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 7);
    tbl[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 7);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 7'b0110000, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 7'b0010000, 0);

    idle_in();
    start4 = 1'b0;
    dc4    = '0;
    chi4.src_start = 1'b0;
    chi4.src_stop  = 1'b0;
    chi4.src_xfer  = 1'b0;
    chi4.dst_start = 1'b0;
    chi4.dst_end   = 1'b0;
    chi4.dst_xfer  = 1'b0;
    chi4.ocnt      = 16'h55;
    rst = 1'b1;
    repeat (3) cyc();
    chk("reset_outs", {outs(), result_cnt}, '0);
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 14; i++) begin
      start         = tbl[i].st;
      abort         = tbl[i].ab;
      dc            = tbl[i].d;
      chi.src_start = tbl[i].ss;
      chi.src_stop  = tbl[i].sp;
      chi.src_xfer  = tbl[i].sx;
      chi.dst_start = tbl[i].ds;
      chi.dst_end   = tbl[i].de;
      chi.dst_xfer  = tbl[i].dx;
      chi.ocnt      = tbl[i].oc;
      #3;
      chk($sformatf("vec%0d_outs", i), outs(), tbl[i].eo);
      chk($sformatf("vec%0d_res", i), result_cnt, tbl[i].er);
      cyc();
    end
    idle_in();
    cyc();

    // 512-beat job with a stop/restart gap
    start = 1'b1;
    dc    = 24'd4096;
    cyc();
    start         = 1'b0;
    chi.src_start = 1'b1;
    cnt = 0; stop_k = -1; gap_bad = 0; last_bad = 0;
    for (int k = 0; k < 1500 && cnt < 512; k++) begin
      chi.src_xfer = 1'b0;
      #1;
      if (stop_k >= 0 && k >= stop_k + 2 &&
          k <= stop_k + 11 && chi.rd_req)
        gap_bad++;
      if (stop_k >= 0 && k == stop_k + 11) begin
        chi.src_stop  = 1'b0;
        chi.src_start = 1'b1;
      end
      chi.src_xfer = chi.rd_req;
      if (chi.rd_req) begin
        if (chi.src_last != (cnt == 511)) last_bad++;
        cnt++;
      end
      if (cnt == 256 && stop_k < 0) begin
        stop_k        = k;
        chi.src_stop  = 1'b1;
        chi.src_start = 1'b0;
      end
      cyc();
    end
    chk("big_beats", cnt, 512);
    chk("big_gap_rdreq", gap_bad, 0);
    chk("big_src_last", last_bad, 0);
    chi.src_xfer = 1'b1;
    cyc();
    chi.src_xfer = 1'b0;
    #1;
    chk("big_extra_err", {busy, err}, 2'b11);
    chi.dst_end = 1'b1;
    cyc();
    chi.dst_end = 1'b0;
    #1;
    chk("big_done_err", {done, err}, 2'b11);
    idle_in();
    cyc();

    // abort five cycles into RUN, 3 of 8 beats moved
    start = 1'b1;
    dc    = 24'd64;
    cyc();
    start         = 1'b0;
    chi.src_start = 1'b1;
    chi.dst_start = 1'b1;
    chi.ocnt      = 16'd33;
    cyc(); cyc(); cyc();
    repeat (3) begin
      chi.src_xfer = 1'b1;
      cyc();
    end
    chi.src_xfer = 1'b0;
    #1;
    chk("abt_pre_req", {chi.rd_req, chi.wr_req}, 2'b11);
    cyc();
    abort = 1'b1;
    #1;
    chk("abt_reqs_low", {chi.rd_req, chi.wr_req}, 2'b00);
    chk("abt_mreset", chi.m_reset, 1'b1);
    cyc();
    abort = 1'b0;
    #1;
    chk("abt_done", {done, err, busy, chi.m_reset},
        4'b1100);
    chk("abt_result", result_cnt, 16'd0);
    cyc();
    chk("abt_done_1cyc", done, 1'b0);
    idle_in();
    cyc();

    // watchdog on the TMO_W=4 instance
    start4 = 1'b1;
    dc4    = 24'd8;
    cyc();
    start4 = 1'b0;
    first  = -1;
    for (int k = 1; k <= 25; k++) begin
      #1;
      if (done4 && first < 0) begin
        first = k;
        chk("tmo_err", {err4, result4}, {1'b1, 16'h55});
      end
      cyc();
    end
    chk("tmo_done_cycle", first, 18);

    // reset mid-RUN, then a fresh job
    start = 1'b1;
    dc    = 24'd16;
    cyc();
    start         = 1'b0;
    chi.src_start = 1'b1;
    repeat (4) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_mid_outs", outs(), 7'b0);
    first = 0;
    repeat (5) begin
      #1;
      if (done) first++;
      cyc();
    end
    chk("rst_no_done", first, 0);
    idle_in();
    run_job(24'd8, 16'h1234, je, jr, js);
    chk("job8_seen", js, 1);
    chk("job8_err", je, 1'b0);
    chk("job8_result", jr, 16'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
